// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encodings, frame
// constants and the baud timing derivation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Clamped to 4 so an unconfigured instance still elaborates to a sane counter.
   function automatic int calcCycle(input int clkFrq, input int baudRate);
      int cycles;
      if (baudRate <= 0) begin
         cycles = 4;
      end else begin
         cycles = clkFrq / baudRate;
      end
      if (cycles < 4) begin
         cycles = 4;
      end
      return cycles;
   endfunction

   function automatic int calcHalf(input int clkFrq, input int baudRate);
      return calcCycle(clkFrq, baudRate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head read, so the
// storage array can map onto block RAM.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          doPush;
   logic          doPop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);

   // The head register looks one entry ahead; a push landing on the new head
   // slot is forwarded straight from the write data.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + AW'(1);
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end
      if (doPush && !doPop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (doPop && !doPush) begin
         count_d = count_q - (AW+1)'(1);
      end
      if (doPush && (wrPtr_q == rdPtr_d)) begin
         rdata_d = wdata_i;
      end else begin
         rdata_d = mem[rdPtr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         rdata_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;
   assign count_o = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit start validation, stop-bit framing check and
// a receive FIFO carrying sticky overrun and framing flags.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_FRQ   = 0,
   parameter int BAUD_RATE = 0,
   parameter int FIFO_AW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_in,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_read,
   output logic [FIFO_AW:0] rx_count,
   output logic             overrun_err,
   output logic             frame_err,
   input  logic             err_clear
);

   localparam int          CYCLE    = calcCycle(CLK_FRQ, BAUD_RATE);
   localparam int          HALF     = calcHalf(CLK_FRQ, BAUD_RATE);
   localparam logic [15:0] CYCLE_M1 = 16'(CYCLE - 1);
   localparam logic [15:0] HALF_M1  = 16'(HALF - 1);
   localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bitIdx_q, bitIdx_d;
   logic [7:0]  shift_q, shift_d;
   logic        sync0_q, sync1_q, syncPrev_q;
   logic        overrun_q, frameErr_q;
   logic        fallEdge;
   logic        pushByte;
   logic        frameErrSet;
   logic        overrunSet;
   logic        fifoFull;
   logic        fifoEmpty;

   // Synchronizer idles high so a reset never fakes a start edge on an idle line.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0_q    <= 1'b1;
         sync1_q    <= 1'b1;
         syncPrev_q <= 1'b1;
      end else begin
         sync0_q    <= rx_in;
         sync1_q    <= sync0_q;
         syncPrev_q <= sync1_q;
      end
   end

   assign fallEdge = syncPrev_q && !sync1_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      pushByte    = 1'b0;
      frameErrSet = 1'b0;
      case (state_q)
         IDLE: begin
            if (fallEdge) begin
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               if (sync1_q) begin
                  state_d = IDLE;
               end else begin
                  cnt_d    = '0;
                  bitIdx_d = '0;
                  state_d  = DATA;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (cnt_q == CYCLE_M1) begin
               shift_d[bitIdx_q] = sync1_q;
               cnt_d             = '0;
               if (bitIdx_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            // Leaving at mid stop bit keeps a back-to-back start edge visible.
            if (cnt_q == CYCLE_M1) begin
               if (sync1_q) begin
                  pushByte = 1'b1;
               end else begin
                  frameErrSet = 1'b1;
               end
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
      end
   end

   assign overrunSet = pushByte && fifoFull && !rx_read;

   // Set beats clear so an error arriving with err_clear is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         if (overrunSet) begin
            overrun_q <= 1'b1;
         end else if (err_clear) begin
            overrun_q <= 1'b0;
         end
         if (frameErrSet) begin
            frameErr_q <= 1'b1;
         end else if (err_clear) begin
            frameErr_q <= 1'b0;
         end
      end
   end

   uart_rx_fifo #(
      .AW (FIFO_AW),
      .DW (8)
   ) rxFifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (pushByte),
      .wdata_i (shift_d),
      .pop_i   (rx_read),
      .rdata_o (rx_data),
      .count_o (rx_count),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign rx_valid    = !fifoEmpty;
   assign overrun_err = overrun_q;
   assign frame_err   = frameErr_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: a 16-deep and a 4-deep instance share
// the serial line, pop strobe and error clear.
module tb_uart_rx_buffered;

   logic       clk;
   logic       reset;
   logic       rx_in;
   logic       rx_read;
   logic       err_clear;

   logic [7:0] data4, data2;
   logic       valid4, valid2;
   logic [4:0] count4;
   logic [2:0] count2;
   logic       ovr4, ovr2;
   logic       ferr4, ferr2;

   int checks;
   int failures;

   uart_rx_buffered #(
      .CLK_FRQ   (1_600_000),
      .BAUD_RATE (100_000),
      .FIFO_AW   (4)
   ) dut4 (
      .clk         (clk),
      .reset       (reset),
      .rx_in       (rx_in),
      .rx_data     (data4),
      .rx_valid    (valid4),
      .rx_read     (rx_read),
      .rx_count    (count4),
      .overrun_err (ovr4),
      .frame_err   (ferr4),
      .err_clear   (err_clear)
   );

   uart_rx_buffered #(
      .CLK_FRQ   (1_600_000),
      .BAUD_RATE (100_000),
      .FIFO_AW   (2)
   ) dut2 (
      .clk         (clk),
      .reset       (reset),
      .rx_in       (rx_in),
      .rx_data     (data2),
      .rx_valid    (valid2),
      .rx_read     (rx_read),
      .rx_count    (count2),
      .overrun_err (ovr2),
      .frame_err   (ferr2),
      .err_clear   (err_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame timing with CYCLE=16: the first edge seeing the start bit is edge 1,
   // the stop bit is sampled (and the byte pushed) on edge 155.
   task automatic sendFrame(input logic [7:0] data, input logic stopBit,
                            input bit readAtPush, input bit resetMid,
                            input int edgesToRun,
                            output logic v154, output logic v155);
      logic [9:0] bits;
      int e;
      bits = {1'b1, stopBit, data};
      v154 = 1'b0;
      v155 = 1'b0;
      rx_in = 1'b0;
      e = 0;
      while (e < edgesToRun) begin
         @(posedge clk);
         e++;
         #1;
         if (e % 16 == 0) rx_in = bits[e/16 - 1];
         if (readAtPush) rx_read = (e == 154);
         if (resetMid) reset = (e == 69);
         if (e == 154) v154 = valid4;
         if (e == 155) v155 = valid4;
      end
   endtask

   task automatic applyReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic pulseRead();
      rx_read = 1'b1;
      @(posedge clk);
      #1;
      rx_read = 1'b0;
   endtask

   task automatic test_reset();
      applyReset();
      checks++;
      if (valid4 !== 1'b0 || count4 !== 5'd0 || data4 !== 8'h00 || ovr4 !== 1'b0 || ferr4 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_state: valid=%b count=%0d data=%h ovr=%b ferr=%b, required 0 0 00 0 0",
                  valid4, count4, data4, ovr4, ferr4);
      end
      checks++;
      if (valid2 !== 1'b0 || count2 !== 3'd0 || data2 !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_state_small: valid=%b count=%0d data=%h, required 0 0 00", valid2, count2, data2);
      end
   endtask

   task automatic test_single_byte();
      logic v154, v155;
      sendFrame(8'h55, 1'b1, 1'b0, 1'b0, 160, v154, v155);
      checks++;
      if (v154 !== 1'b0 || v155 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL push_latency: valid before/after push edge=%b/%b, required 0/1", v154, v155);
      end
      checks++;
      if (valid4 !== 1'b1 || data4 !== 8'h55 || count4 !== 5'd1 || ovr4 !== 1'b0 || ferr4 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL byte_55: valid=%b data=%h count=%0d ovr=%b ferr=%b, required 1 55 1 0 0",
                  valid4, data4, count4, ovr4, ferr4);
      end
      pulseRead();
      checks++;
      if (valid4 !== 1'b0 || count4 !== 5'd0) begin
         failures++;
         $display("[TB] FAIL pop_55: valid=%b count=%0d, required 0 0", valid4, count4);
      end
   endtask

   task automatic test_false_start();
      logic v154, v155;
      rx_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (valid4 !== 1'b0 || count4 !== 5'd0 || ferr4 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL false_start: valid=%b count=%0d ferr=%b, required 0 0 0", valid4, count4, ferr4);
      end
      sendFrame(8'hC3, 1'b1, 1'b0, 1'b0, 160, v154, v155);
      checks++;
      if (valid4 !== 1'b1 || data4 !== 8'hC3 || count4 !== 5'd1) begin
         failures++;
         $display("[TB] FAIL byte_C3: valid=%b data=%h count=%0d, required 1 C3 1", valid4, data4, count4);
      end
      pulseRead();
   endtask

   task automatic test_framing();
      logic v154, v155;
      sendFrame(8'hA3, 1'b0, 1'b0, 1'b0, 160, v154, v155);
      checks++;
      if (ferr4 !== 1'b1 || count4 !== 5'd0 || valid4 !== 1'b0 || ovr4 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL frame_err_set: ferr=%b count=%0d valid=%b ovr=%b, required 1 0 0 0",
                  ferr4, count4, valid4, ovr4);
      end
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
      checks++;
      if (ferr4 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL frame_err_clear: ferr=%b, required 0", ferr4);
      end
   endtask

   task automatic test_overrun();
      logic v154, v155;
      logic [7:0] expected [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      applyReset();
      for (int i = 1; i <= 5; i++) begin
         sendFrame(8'(i), 1'b1, 1'b0, 1'b0, 160, v154, v155);
      end
      checks++;
      if (count2 !== 3'd4 || ovr2 !== 1'b1 || valid2 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL overrun_set: count=%0d ovr=%b valid=%b, required 4 1 1", count2, ovr2, valid2);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (data2 !== expected[i]) begin
            failures++;
            $display("[TB] FAIL overrun_pop%0d: data=%h, required %h", i, data2, expected[i]);
         end
         pulseRead();
      end
      checks++;
      if (valid2 !== 1'b0 || count2 !== 3'd0) begin
         failures++;
         $display("[TB] FAIL overrun_drained: valid=%b count=%0d, required 0 0", valid2, count2);
      end
   endtask

   task automatic test_back_to_back();
      logic v154, v155;
      logic [7:0] expected [4] = '{8'h02, 8'h03, 8'h04, 8'h99};
      applyReset();
      for (int i = 1; i <= 4; i++) begin
         sendFrame(8'(i), 1'b1, 1'b0, 1'b0, 160, v154, v155);
      end
      sendFrame(8'h99, 1'b1, 1'b1, 1'b0, 160, v154, v155);
      checks++;
      if (ovr2 !== 1'b0 || count2 !== 3'd4) begin
         failures++;
         $display("[TB] FAIL full_push_pop: ovr=%b count=%0d, required 0 4", ovr2, count2);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (data2 !== expected[i]) begin
            failures++;
            $display("[TB] FAIL full_pop%0d: data=%h, required %h", i, data2, expected[i]);
         end
         pulseRead();
      end
   endtask

   task automatic test_reset_mid_frame();
      logic v154, v155;
      sendFrame(8'hF8, 1'b1, 1'b0, 1'b0, 160, v154, v155);
      checks++;
      if (valid4 !== 1'b1 || count4 !== 5'd1 || data4 !== 8'hF8) begin
         failures++;
         $display("[TB] FAIL pre_reset_byte: valid=%b count=%0d data=%h, required 1 1 F8", valid4, count4, data4);
      end
      err_clear = 1'b0;
      sendFrame(8'hF8, 1'b1, 1'b0, 1'b1, 70, v154, v155);
      checks++;
      if (valid4 !== 1'b0 || count4 !== 5'd0 || data4 !== 8'h00 || ovr4 !== 1'b0 || ferr4 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_frame_reset: valid=%b count=%0d data=%h ovr=%b ferr=%b, required 0 0 00 0 0",
                  valid4, count4, data4, ovr4, ferr4);
      end
      rx_in = 1'b1;
      repeat (120) @(posedge clk);
      #1;
      checks++;
      if (valid4 !== 1'b0 || count4 !== 5'd0 || ferr4 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abandoned_frame: valid=%b count=%0d ferr=%b, required 0 0 0", valid4, count4, ferr4);
      end
      sendFrame(8'h7E, 1'b1, 1'b0, 1'b0, 160, v154, v155);
      checks++;
      if (data4 !== 8'h7E || count4 !== 5'd1 || valid4 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL byte_7E: data=%h count=%0d valid=%b, required 7E 1 1", data4, count4, valid4);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      rx_in     = 1'b1;
      rx_read   = 1'b0;
      err_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      repeat (5) @(posedge clk);
      #1;
      test_single_byte();
      test_false_start();
      test_framing();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
